// File: rtl/cpu16_core_if.sv
// cpu16_core_if: instruction-fetch and I/O strobe bundle between cpu16_core (master)
// and the instruction ROM / I/O decode (slave).
interface cpu16_core_if;
  logic [15:0] address;
  logic [31:0] data;
  logic        rd;
  logic        hlt;
  logic        io_rd;
  logic        io_wr;

  modport master (output address, rd, hlt, io_rd, io_wr, input data);
  modport slave  (input address, rd, hlt, io_rd, io_wr, output data);
endinterface

// File: rtl/cpu16_core.sv
// cpu16_core: 16-bit register CPU, one instruction per FETCH/EXEC pair, internal call stack.
// Define CPU16_IO_EN to implement the strobed IN/OUT port; otherwise opcodes 18/19 are NOPs.
module cpu16_core #(
  parameter int STACK_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  cpu16_core_if.master bus,
  inout  wire  [15:0]  io_data
);
  localparam int SPW = $clog2(STACK_DEPTH);

  localparam logic [4:0] OP_JMP  = 5'd1;
  localparam logic [4:0] OP_JZ   = 5'd2;
  localparam logic [4:0] OP_JNZ  = 5'd3;
  localparam logic [4:0] OP_JC   = 5'd4;
  localparam logic [4:0] OP_JNC  = 5'd5;
  localparam logic [4:0] OP_LDI  = 5'd6;
  localparam logic [4:0] OP_MOV  = 5'd7;
  localparam logic [4:0] OP_ADD  = 5'd8;
  localparam logic [4:0] OP_CALL = 5'd9;
  localparam logic [4:0] OP_SUB  = 5'd10;
  localparam logic [4:0] OP_AND  = 5'd11;
  localparam logic [4:0] OP_OR   = 5'd12;
  localparam logic [4:0] OP_XOR  = 5'd13;
  localparam logic [4:0] OP_ADDI = 5'd14;
  localparam logic [4:0] OP_SHL  = 5'd15;
  localparam logic [4:0] OP_SHR  = 5'd16;
  localparam logic [4:0] OP_RET  = 5'd17;
`ifdef CPU16_IO_EN
  localparam logic [4:0] OP_IN   = 5'd18;
  localparam logic [4:0] OP_OUT  = 5'd19;
`endif
  localparam logic [4:0] OP_HLT  = 5'd31;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t         r_state, w_state_next;
  logic [15:0]    r_pc, w_pc_next, w_pc_inc;
  logic [SPW-1:0] r_sp, w_sp_next, w_sp_dec;
  logic           r_z, r_c, w_z_next, w_c_next;
  logic [15:0]    r_regs  [16];
  logic [15:0]    r_stack [STACK_DEPTH];

  logic [4:0]     w_op;
  logic [3:0]     w_rd_idx, w_rs_idx;
  logic [15:0]    w_imm, w_rd_val, w_rs_val, w_stack_top;
  logic           w_reg_we, w_set_z, w_push;
  logic [15:0]    w_reg_wdata;
  logic [16:0]    w_wide;
  logic [15:0]    w_address;
  logic           w_rd_strobe, w_io_rd, w_io_wr;

  assign w_op        = bus.data[4:0];
  assign w_rd_idx    = bus.data[11:8];
  assign w_rs_idx    = bus.data[15:12];
  assign w_imm       = bus.data[31:16];
  assign w_rd_val    = r_regs[w_rd_idx];
  assign w_rs_val    = r_regs[w_rs_idx];
  assign w_pc_inc    = r_pc + 16'd1;
  assign w_sp_dec    = r_sp - SPW'(1);
  assign w_stack_top = r_stack[w_sp_dec];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_sp_next    = r_sp;
    w_z_next     = r_z;
    w_c_next     = r_c;
    w_reg_we     = 1'b0;
    w_reg_wdata  = '0;
    w_set_z      = 1'b0;
    w_push       = 1'b0;
    w_wide       = '0;
    w_address    = r_pc;
    w_rd_strobe  = 1'b0;
    w_io_rd      = 1'b0;
    w_io_wr      = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_rd_strobe  = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_state_next = S_FETCH;
        w_pc_next    = w_pc_inc;
        case (w_op)
          OP_JMP: w_pc_next = w_imm;
          OP_JZ:  if (r_z)  w_pc_next = w_imm;
          OP_JNZ: if (!r_z) w_pc_next = w_imm;
          OP_JC:  if (r_c)  w_pc_next = w_imm;
          OP_JNC: if (!r_c) w_pc_next = w_imm;
          OP_LDI: begin w_reg_we = 1'b1; w_reg_wdata = w_imm;    w_set_z = 1'b1; w_c_next = 1'b0; end
          OP_MOV: begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val; w_set_z = 1'b1; w_c_next = 1'b0; end
          OP_AND: begin w_reg_we = 1'b1; w_reg_wdata = w_rd_val & w_rs_val; w_set_z = 1'b1; w_c_next = 1'b0; end
          OP_OR:  begin w_reg_we = 1'b1; w_reg_wdata = w_rd_val | w_rs_val; w_set_z = 1'b1; w_c_next = 1'b0; end
          OP_XOR: begin w_reg_we = 1'b1; w_reg_wdata = w_rd_val ^ w_rs_val; w_set_z = 1'b1; w_c_next = 1'b0; end
          OP_ADD, OP_ADDI, OP_SUB: begin
            // 17-bit result: bit 16 is carry-out for adds, borrow for SUB
            if (w_op == OP_SUB)       w_wide = {1'b0, w_rd_val} - {1'b0, w_rs_val};
            else if (w_op == OP_ADD)  w_wide = {1'b0, w_rd_val} + {1'b0, w_rs_val};
            else                      w_wide = {1'b0, w_rd_val} + {1'b0, w_imm};
            w_reg_we    = 1'b1;
            w_reg_wdata = w_wide[15:0];
            w_set_z     = 1'b1;
            w_c_next    = w_wide[16];
          end
          OP_SHL: begin w_reg_we = 1'b1; w_reg_wdata = {w_rd_val[14:0], 1'b0}; w_set_z = 1'b1; w_c_next = w_rd_val[15]; end
          OP_SHR: begin w_reg_we = 1'b1; w_reg_wdata = {1'b0, w_rd_val[15:1]}; w_set_z = 1'b1; w_c_next = w_rd_val[0]; end
          OP_CALL: begin
            w_push    = 1'b1;
            w_sp_next = r_sp + SPW'(1);
            w_pc_next = w_imm;
          end
          OP_RET: begin
            w_sp_next = w_sp_dec;
            w_pc_next = w_stack_top;
          end
`ifdef CPU16_IO_EN
          OP_IN: begin
            w_address   = w_imm;
            w_io_rd     = 1'b1;
            w_reg_we    = 1'b1;
            w_reg_wdata = io_data;
          end
          OP_OUT: begin
            w_address = w_imm;
            w_io_wr   = 1'b1;
          end
`endif
          OP_HLT: w_state_next = S_HALT;
          default: ;
        endcase
        if (w_set_z) w_z_next = (w_reg_wdata == 16'h0000);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_sp    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_sp    <= w_sp_next;
      r_z     <= w_z_next;
      r_c     <= w_c_next;
      if (w_reg_we) r_regs[w_rd_idx] <= w_reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[r_sp] <= w_pc_inc;
  end

  // Reset forces every output quiet combinationally, not just from the next edge.
  assign bus.address = reset ? 16'h0000 : w_address;
  assign bus.rd      = w_rd_strobe && !reset;
  assign bus.hlt     = (r_state == S_HALT) && !reset;
  assign bus.io_rd   = w_io_rd && !reset;
  assign bus.io_wr   = w_io_wr && !reset;

`ifdef CPU16_IO_EN
  assign io_data = (w_io_wr && !reset) ? w_rs_val : 16'hzzzz;
  logic w_unused;
  assign w_unused = &{1'b0, bus.data[7:5]};
`else
  assign io_data = 16'hzzzz;
  logic w_unused;
  assign w_unused = &{1'b0, bus.data[7:5], io_data};
`endif
endmodule

// File: tb/tb_cpu16_core.sv
// tb_cpu16_core: directed programs in a behavioural ROM; expected fetch/I-O/halt events are
// queued per program and a negedge monitor pops and compares each event the core presents.
module tb_cpu16_core;
  localparam int K_FETCH = 0;
  localparam int K_OUT   = 1;
  localparam int K_IN    = 2;
  localparam int K_HALT  = 3;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [15:0] io_data;
  logic [31:0] rom [0:63];
  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  cpu16_core_if bus();

  cpu16_core #(.STACK_DEPTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .io_data (io_data)
  );

  always #5 clk = ~clk;

  assign io_data = bus.io_rd ? 16'hBEEF : 16'hzzzz;

  always @(posedge clk) begin
    if (bus.rd) bus.data <= rom[bus.address[5:0]];
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] imm);
    return {imm, rs, rd, 3'b000, op};
  endfunction

  task automatic push_ev(input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ef(input logic [15:0] a);
    push_ev(K_FETCH, a, 16'h0);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000001F;
  endtask

  task automatic check_event(input int kind, input logic [15:0] a, input logic [15:0] d,
                             input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: unexpected event addr=0x%04h data=0x%04h, required no event", name, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != a || (kind == K_OUT && e.data != d)) begin
        n_errors++;
        $display("FAIL %s: got kind=%0d addr=0x%04h data=0x%04h, required kind=%0d addr=0x%04h data=0x%04h",
                 name, kind, a, d, e.kind, e.addr, e.data);
      end else begin
        $display("ok   %s addr=0x%04h data=0x%04h", name, a, d);
      end
    end
  endtask

  // Monitor
  initial begin
    int  cyc;
    int  rst_cyc;
    int  last_fetch;
    logic hlt_prev;
    cyc = 0; rst_cyc = 0; last_fetch = -1; hlt_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        n_checks++;
        if (bus.rd || bus.address != 16'h0 || bus.hlt || bus.io_rd || bus.io_wr) begin
          n_errors++;
          $display("FAIL reset_outputs: rd=%0b address=0x%04h hlt=%0b io_rd=%0b io_wr=%0b, required all 0",
                   bus.rd, bus.address, bus.hlt, bus.io_rd, bus.io_wr);
        end
        rst_cyc = cyc; last_fetch = -1; hlt_prev = 1'b0;
      end else begin
        if (bus.rd) begin
          n_checks++;
          if (last_fetch < 0 && cyc - rst_cyc != 1) begin
            n_errors++;
            $display("FAIL first_fetch: came %0d cycles after reset, required 1", cyc - rst_cyc);
          end else if (last_fetch >= 0 && cyc - last_fetch != 2) begin
            n_errors++;
            $display("FAIL fetch_spacing: gap=%0d cycles, required 2", cyc - last_fetch);
          end
          last_fetch = cyc;
          check_event(K_FETCH, bus.address, 16'h0, "fetch");
        end
        if (bus.io_wr) check_event(K_OUT, bus.address, io_data, "out");
        if (bus.io_rd) check_event(K_IN, bus.address, 16'h0, "in");
        if (bus.hlt && !hlt_prev) check_event(K_HALT, 16'h0, 16'h0, "halt");
        if (bus.hlt) begin
          n_checks++;
          if (bus.rd) begin
            n_errors++;
            $display("FAIL halted_rd: rd=1 while hlt=1, required 0");
          end
        end
        hlt_prev = bus.hlt;
      end
    end
  end

  task automatic start_test(input int hold);
    repeat (hold) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait for every expected event, optionally settle, then leave the core in reset.
  task automatic drain(input int budget, input string name, input bit settle);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    if (settle) begin
      repeat (4) @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;

    // Loop program with CALL/RET; never halts
    rom_clear();
    rom[0] = 32'h00000000; rom[1] = 32'h00030001; rom[2] = 32'h0000001F;
    rom[3] = 32'h00050009; rom[4] = 32'h00000001; rom[5] = 32'h00000011;
    rom[6] = 32'h0000001F;
    repeat (2) begin ef(0); ef(1); ef(3); ef(5); ef(4); end
    start_test(3);
    drain(100, "loop", 1'b0);

    // ADD wraps to zero, JZ taken to HLT at 10; reset held longer first
    rom_clear();
    rom[0] = enc(6, 1, 0, 16'hFFFF);
    rom[1] = enc(6, 2, 0, 16'h0001);
    rom[2] = enc(8, 1, 2, 16'h0000);
    rom[3] = enc(2, 0, 0, 16'd10);
    ef(0); ef(1); ef(2); ef(3); ef(10); push_ev(K_HALT, 0, 0);
    start_test(6);
    drain(100, "alu_jz", 1'b1);

    // Flag paths: any wrong flag lands on HLT at 30 or 15/27
    rom_clear();
    rom[0]  = enc(6, 1, 0, 16'h8001);
    rom[1]  = enc(15, 1, 0, 16'h0);
    rom[2]  = enc(5, 0, 0, 16'd30);
    rom[3]  = enc(16, 1, 0, 16'h0);
    rom[4]  = enc(4, 0, 0, 16'd30);
    rom[5]  = enc(10, 1, 1, 16'h0);
    rom[6]  = enc(3, 0, 0, 16'd30);
    rom[7]  = enc(6, 2, 0, 16'h0005);
    rom[8]  = enc(10, 1, 2, 16'h0);
    rom[9]  = enc(4, 0, 0, 16'd12);
    rom[12] = enc(13, 1, 1, 16'h0);
    rom[13] = enc(4, 0, 0, 16'd30);
    rom[14] = enc(2, 0, 0, 16'd16);
    rom[16] = enc(14, 2, 0, 16'hFFFB);
    rom[17] = enc(3, 0, 0, 16'd30);
    rom[18] = enc(5, 0, 0, 16'd30);
    rom[19] = enc(6, 3, 0, 16'h00F0);
    rom[20] = enc(11, 3, 2, 16'h0);
    rom[21] = enc(3, 0, 0, 16'd30);
    rom[22] = enc(20, 0, 0, 16'h0);
    rom[23] = enc(7, 5, 3, 16'h0);
    rom[24] = enc(4, 0, 0, 16'd30);
    rom[25] = enc(12, 6, 1, 16'h0);
    rom[26] = enc(2, 0, 0, 16'd28);
    for (int a = 0; a <= 9; a++) ef(16'(a));
    ef(12); ef(13); ef(14);
    for (int a = 16; a <= 26; a++) ef(16'(a));
    ef(28); push_ev(K_HALT, 0, 0);
    start_test(2);
    drain(200, "flags", 1'b1);

    // I/O: OUT R3, IN R4 (bench drives 0xBEEF), OUT R4
    rom_clear();
    rom[0] = enc(6, 3, 0, 16'h1234);
    rom[1] = enc(19, 0, 3, 16'h0040);
    rom[2] = enc(18, 4, 0, 16'h0041);
    rom[3] = enc(19, 0, 4, 16'h0042);
    ef(0); ef(1);
`ifdef CPU16_IO_EN
    push_ev(K_OUT, 16'h0040, 16'h1234);
`endif
    ef(2);
`ifdef CPU16_IO_EN
    push_ev(K_IN, 16'h0041, 16'h0);
`endif
    ef(3);
`ifdef CPU16_IO_EN
    push_ev(K_OUT, 16'h0042, 16'hBEEF);
`endif
    ef(4); push_ev(K_HALT, 0, 0);
    start_test(2);
    drain(100, "io", 1'b1);

    // 17 nested CALLs wrap the 16-entry stack, then RETs
    rom_clear();
    for (int k = 0; k <= 16; k++) begin
      rom[2*k]   = enc(9, 0, 0, 16'(2*k + 2));
      rom[2*k+1] = enc(17, 0, 0, 16'h0);
    end
    rom[34] = enc(17, 0, 0, 16'h0);
    for (int k = 0; k <= 16; k++) ef(16'(2*k));
    ef(34);
    for (int v = 33; v >= 3; v -= 2) ef(16'(v));
    ef(33); ef(31);
    start_test(2);
    drain(300, "stack_wrap", 1'b0);

    // Reset during EXEC of a CALL that would overwrite stack entry 15
    rom_clear();
    for (int k = 0; k <= 15; k++) rom[2*k] = enc(9, 0, 0, 16'(2*k + 2));
    rom[32] = enc(17, 0, 0, 16'h0);
    rom[31] = enc(9, 0, 0, 16'd40);
    for (int k = 0; k <= 15; k++) ef(16'(2*k));
    ef(32); ef(31);
    start_test(2);
    drain(200, "call_abort_a", 1'b0);
    rom_clear();
    rom[0] = enc(17, 0, 0, 16'h0);
    ef(0); ef(31); push_ev(K_HALT, 0, 0);
    start_test(3);
    drain(100, "call_abort_b", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu16_core.md
# cpu16_core

16-bit accumulator-free register CPU with 32-bit instruction words, a 16-bit program address space, an internal call stack and a simple strobed I/O port. It fetches from an external instruction ROM via `address`/`rd`/`data`. It executes one instruction every two clock cycles and stops on HLT until reset.

## Interface
- `STACK_DEPTH`, 16: number of return-address entries in the internal call stack (power of two).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  out  16  instruction address (PC) or I/O port address.
- `data`  in  32  instruction word from ROM.
- `rd`  out  1  fetch strobe; ROM presents `data` after its falling edge.
- `hlt`  out  1  high once HLT has executed.
- `io_rd`  out  1  I/O read strobe.
- `io_wr`  out  1  I/O write strobe.
- `io_data`  inout  16  I/O data; CPU drives only while `io_wr`=1, else high-Z.

## Operation
- Instruction fields:
  - `op`=data[4:0]
  - `rd`=data[11:8]
  - `rs`=data[15:12]
  - `imm`=data[31:16]
- State:
  - PC (16b)
  - R0–R15 (16b)
  - flags Z, C
  - stack of STACK_DEPTH×16b with pointer SP.
- Opcodes:
  - 0 NOP
  - 1 JMP imm
  - 2 JZ, 3 JNZ, 4 JC, 5 JNC imm
  - 6 LDI rd←imm
  - 7 MOV rd←rs
  - 8 ADD rd←rd+rs
  - 9 CALL imm: push PC+1, PC←imm
  - 10 SUB rd←rd−rs (C=borrow)
  - 11 AND, 12 OR, 13 XOR
  - 14 ADDI rd←rd+imm
  - 15 SHL rd (C=old bit15)
  - 16 SHR rd (C=old bit0)
  - 17 RET: pop into PC
  - 18 IN rd←port[imm]
  - 19 OUT port[imm]←rs
  - 31 HLT
  - all other codes behave as NOP.
- Arithmetic:
  - 16-bit modular; Z = result==0.
  - C = carry-out (ADD/ADDI), borrow (SUB), shifted-out bit (shifts).
  - AND/OR/XOR/MOV/LDI set Z and clear C.
  - Other instructions leave the flags unchanged.
- Non-branching instructions and untaken branches: PC←PC+1, wrapping 0xFFFF→0.
- Stack:
  - push writes stack[SP] and then SP←SP+1; pop does SP←SP−1 and then reads.
  - SP wraps modulo STACK_DEPTH, with no fault on overflow or underflow.
- HLT: `hlt`←1, the CPU stops fetching, and `rd` stays 0 until reset.

## Timing
- FSM states: FETCH → EXEC → FETCH …; HALT is terminal.
- FETCH (1 cycle): `rd`=1, `address`=PC.
- EXEC (1 cycle):
  - `rd`=0.
  - The instruction is decoded from `data` and all register, flag, PC and stack updates take effect on the rising edge ending EXEC.
  - Throughput is 2 cycles per instruction, including branches, CALL and RET.
- IN during EXEC: `address`=imm, `io_rd`=1; `io_data` is sampled on the edge ending EXEC.
- OUT during EXEC: `address`=imm, `io_wr`=1, `io_data`=R[rs].
- Other EXECs: `address`=PC, `io_rd`=`io_wr`=0.
- Reset:
  - While `reset`=1, at every edge: PC=0, SP=0, R*=0, Z=C=0, state=FETCH.
  - Outputs during and after reset: `address`=0, `rd`=0, `hlt`=0, `io_rd`=`io_wr`=0, `io_data`=Z.
  - First cycle after deassertion is FETCH of address 0 with `rd`=1.
- Reset mid-EXEC or in HALT aborts the instruction and takes priority; no partial update occurs.

## Configuration
- `CPU16_IO_EN`:
  - Defined: IN/OUT implemented as above.
  - Undefined: opcodes 18/19 execute as NOP; `io_rd`=`io_wr`=0 permanently; `io_data` permanently high-Z; `address`=PC in every EXEC.

## Test plan
- ROM {0:0x0, 1:0x00030001, 2:0x1F, 3:0x00050009, 4:0x00000001, 5:0x00000011, 6:0x1F}, reset pulse then run:
  - `rd`-high addresses follow 0,1,3,5,4,0,1,3,5,4…
  - `hlt` stays 0
  - each fetch is 2 cycles apart.
- Reset held then released:
  - all outputs 0 and `io_data`=Z during reset.
  - First post-reset cycle has `rd`=1, `address`=0.
- ALU program LDI R1,0xFFFF; LDI R2,1; ADD R1,R2; JZ 10 (target 10 holds HLT):
  - R1=0, Z=1, C=1.
  - Fetch jumps to 10, then `hlt`=1 and fetching stops.
- OUT R3(=0x1234) to port 0x0040, then IN R4 from 0x0041 with bench driving 0xBEEF:
  - One EXEC cycle with `io_wr`=1, `address`=0x0040, `io_data`=0x1234.
  - One EXEC cycle with `io_rd`=1, `address`=0x0041.
  - R4=0xBEEF; a following OUT R4 shows 0xBEEF.
- 17 nested CALLs (STACK_DEPTH=16) followed by RETs:
  - SP wraps with no fault.
  - The first RET returns to the address pushed by the 17th CALL.
- Reset asserted during EXEC of CALL:
  - No stack push, PC=0.
  - Next fetch is from address 0.
